corelet_ctrl: RTL and testbench

Instruction sequencer that drives the 35-bit `inst` word consumed by the corelet, which holds the L0 buffer, MAC array, OFIFO and SFP. It acts as the initiator side of that interface. For each kernel position (kij) it walks weight fill, kernel load, activation fill, execute and OFIFO drain to psum SRAM, then runs a final accumulation pass through the SFP. It sits between the testbench/host `start` handshake and the corelet plus its activation (xmem) and psum (pmem) SRAMs.

---
 rtl/corelet_inst_pkg.sv | 52 +++++
 rtl/phase_counter.sv | 32 +++
 rtl/corelet_ctrl.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_corelet_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/corelet_inst_pkg.sv
// corelet_inst_pkg: shared definitions for the corelet instruction word.
// Holds the 35-bit inst field positions, MAC op codes, the idle word and the
// sequencer state encoding used by corelet_ctrl.
package corelet_inst_pkg;

    localparam int INST_W = 35;
    localparam int ADDR_W = 11;
    localparam int KIJ_W  = 4;

    // Field positions inside inst
    localparam int OP_LSB       = 0;
    localparam int OP_W         = 2;
    localparam int L0_WR_BIT    = 2;
    localparam int L0_RD_BIT    = 3;
    localparam int OFIFO_RD_BIT = 6;
    localparam int XADDR_LSB    = 7;
    localparam int XCEN_BIT     = 18;
    localparam int XWEN_BIT     = 19;
    localparam int PADDR_LSB    = 20;
    localparam int PCEN_BIT     = 31;
    localparam int PWEN_BIT     = 32;
    localparam int SFP_ACC_BIT  = 33;
    localparam int MODE_BIT     = 34;

    // MAC op codes
    localparam logic [1:0] OP_IDLE  = 2'b00;
    localparam logic [1:0] OP_KLOAD = 2'b01;
    localparam logic [1:0] OP_EXEC  = 2'b10;

    // Both SRAMs deselected and write-disabled, everything else low
    localparam logic [INST_W-1:0] IDLE_WORD = 35'h1_800C_0000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_W_FILL = 3'd1,
        ST_W_LOAD = 3'd2,
        ST_A_FILL = 3'd3,
        ST_EXEC   = 3'd4,
        ST_DRAIN  = 3'd5,
        ST_ACC    = 3'd6,
        ST_DONE   = 3'd7
    } state_e;

    // Idle word carrying the given dataflow mode in bit 34
    function automatic logic [INST_W-1:0] idle_word(input logic mode);
        logic [INST_W-1:0] w;
        w           = IDLE_WORD;
        w[MODE_BIT] = mode;
        return w;
    endfunction

endpackage

// File: rtl/phase_counter.sv
// phase_counter: loadable down-counter that measures the beats of one phase.
// Load with (beats-1); `last` is high on the final beat. Decrement stops at 0.
// Ports: clk, rst_n (async active-low), load/load_val, dec, last.
module phase_counter #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         last
);

    logic [W-1:0] cnt_q;

    // Beat counter register: load has priority over decrement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign last = (cnt_q == '0);

endmodule

// File: rtl/corelet_ctrl.sv
// corelet_ctrl: instruction sequencer driving the corelet 35-bit inst word.
// Per kernel position: weight fill, kernel load, activation fill, execute,
// OFIFO drain to psum SRAM; then one SFP accumulation pass over all psums.
// Ports: clk, reset (async active-low), start/mode_os/num_kij/num_act
// (captured on acceptance), ofifo_valid; outputs inst, busy, done (registered).
module corelet_ctrl
    import corelet_inst_pkg::*;
#(
    parameter int          row    = 8,
    parameter int          col    = 8,
    parameter logic [10:0] W_BASE = 11'd1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode_os,
    input  logic [KIJ_W-1:0]  num_kij,
    input  logic [ADDR_W-1:0] num_act,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done
);

    if (row < 1 || col < 1) begin : g_param_check
        $error("corelet_ctrl: row and col must be at least 1");
    end

    localparam logic [ADDR_W-1:0] COL11 = ADDR_W'(col);

    state_e              state_q, state_d;
    logic [KIJ_W-1:0]    k_q, k_d;
    logic [KIJ_W-1:0]    kk_q, kk_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]   o_q, o_d;
    logic                acc_head_q, acc_head_d;
    logic                acc_tail_q, acc_tail_d;
    logic                mode_q, mode_d;
    logic [KIJ_W-1:0]    nkij_q, nkij_d;
    logic [ADDR_W-1:0]   nact_q, nact_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                cnt_load, cnt_dec, cnt_last;
    logic [ADDR_W-1:0]   cnt_val;

    logic [ADDR_W-1:0]   wfill_addr, drain_addr, acc_addr, acc_beats_m1;
    logic                k_is_last, kk_is_last;

    // All address arithmetic wraps modulo 2048
    assign wfill_addr   = W_BASE + ADDR_W'(k_q) * COL11 + idx_q;
    assign drain_addr   = ADDR_W'(k_q) * nact_q + idx_q;
    assign acc_addr     = ADDR_W'(kk_q) * nact_q + o_q;
    assign acc_beats_m1 = ADDR_W'(nkij_q) * nact_q - 11'd1;
    assign k_is_last    = (k_q == nkij_q - 4'd1);
    assign kk_is_last   = (kk_q == nkij_q - 4'd1);

    phase_counter #(.W(ADDR_W)) u_beat (
        .clk      (clk),
        .rst_n    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .last     (cnt_last)
    );

    // Next-state, counter control and next instruction word
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        kk_d       = kk_q;
        idx_d      = idx_q;
        o_d        = o_q;
        acc_head_d = acc_head_q;
        acc_tail_d = acc_tail_q;
        mode_d     = mode_q;
        nkij_d     = nkij_q;
        nact_d     = nact_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        cnt_val    = 11'd0;
        inst_d     = idle_word(mode_q);
        busy_d     = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d     = mode_os;
                    nkij_d     = num_kij;
                    nact_d     = num_act;
                    k_d        = 4'd0;
                    kk_d       = 4'd0;
                    idx_d      = 11'd0;
                    o_d        = 11'd0;
                    acc_head_d = 1'b0;
                    acc_tail_d = 1'b0;
                    if (num_kij == 4'd0 || num_act == 11'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_W_FILL;
                        cnt_load = 1'b1;
                        cnt_val  = COL11;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_W_FILL: begin
                busy_d = 1'b1;
                // Reads on beats 0..col-1, L0 writes one beat later (SRAM latency)
                if (!cnt_last) begin
                    inst_d[XCEN_BIT]                = 1'b0;
                    inst_d[XADDR_LSB +: ADDR_W]     = wfill_addr;
                end else begin
                    inst_d[XCEN_BIT]                = 1'b1;
                end
                if (idx_q != 11'd0) begin
                    inst_d[L0_WR_BIT] = 1'b1;
                end else begin
                    inst_d[L0_WR_BIT] = 1'b0;
                end
                if (cnt_last) begin
                    state_d  = ST_W_LOAD;
                    cnt_load = 1'b1;
                    cnt_val  = COL11 - 11'd1;
                    idx_d    = 11'd0;
                end else begin
                    idx_d   = idx_q + 11'd1;
                    cnt_dec = 1'b1;
                end
            end

            ST_W_LOAD: begin
                busy_d                       = 1'b1;
                inst_d[OP_LSB +: OP_W]       = OP_KLOAD;
                inst_d[L0_RD_BIT]            = 1'b1;
                if (cnt_last) begin
                    state_d  = ST_A_FILL;
                    cnt_load = 1'b1;
                    cnt_val  = nact_q;
                    idx_d    = 11'd0;
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            ST_A_FILL: begin
                busy_d = 1'b1;
                if (!cnt_last) begin
                    inst_d[XCEN_BIT]            = 1'b0;
                    inst_d[XADDR_LSB +: ADDR_W] = idx_q;
                end else begin
                    inst_d[XCEN_BIT]            = 1'b1;
                end
                if (idx_q != 11'd0) begin
                    inst_d[L0_WR_BIT] = 1'b1;
                end else begin
                    inst_d[L0_WR_BIT] = 1'b0;
                end
                if (cnt_last) begin
                    state_d  = ST_EXEC;
                    cnt_load = 1'b1;
                    cnt_val  = nact_q - 11'd1;
                end else begin
                    idx_d   = idx_q + 11'd1;
                    cnt_dec = 1'b1;
                end
            end

            ST_EXEC: begin
                busy_d                 = 1'b1;
                inst_d[OP_LSB +: OP_W] = OP_EXEC;
                inst_d[L0_RD_BIT]      = 1'b1;
                if (cnt_last) begin
                    state_d  = ST_DRAIN;
                    cnt_load = 1'b1;
                    cnt_val  = nact_q - 11'd1;
                    idx_d    = 11'd0;
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            ST_DRAIN: begin
                busy_d = 1'b1;
                // Stall on an empty OFIFO; only valid cycles count as beats
                if (ofifo_valid) begin
                    inst_d[OFIFO_RD_BIT]        = 1'b1;
                    inst_d[PCEN_BIT]            = 1'b0;
                    inst_d[PWEN_BIT]            = 1'b0;
                    inst_d[PADDR_LSB +: ADDR_W] = drain_addr;
                    idx_d                       = idx_q + 11'd1;
                    if (cnt_last) begin
                        if (k_is_last) begin
                            state_d    = ST_ACC;
                            cnt_load   = 1'b1;
                            cnt_val    = acc_beats_m1;
                            kk_d       = 4'd0;
                            o_d        = 11'd0;
                            acc_head_d = 1'b1;
                            acc_tail_d = 1'b0;
                        end else begin
                            state_d  = ST_W_FILL;
                            k_d      = k_q + 4'd1;
                            cnt_load = 1'b1;
                            cnt_val  = COL11;
                            idx_d    = 11'd0;
                        end
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end

            ST_ACC: begin
                busy_d     = 1'b1;
                acc_head_d = 1'b0;
                // SFP accumulates the word read on the previous cycle
                if (!acc_head_q) begin
                    inst_d[SFP_ACC_BIT] = 1'b1;
                end else begin
                    inst_d[SFP_ACC_BIT] = 1'b0;
                end
                if (acc_tail_q) begin
                    state_d = ST_DONE;
                end else begin
                    inst_d[PCEN_BIT]            = 1'b0;
                    inst_d[PADDR_LSB +: ADDR_W] = acc_addr;
                    // Output-major walk: kk is the inner index
                    if (kk_is_last) begin
                        kk_d = 4'd0;
                        o_d  = o_q + 11'd1;
                    end else begin
                        kk_d = kk_q + 4'd1;
                    end
                    if (cnt_last) begin
                        acc_tail_d = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, loop indices, captured operands and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            k_q        <= 4'd0;
            kk_q       <= 4'd0;
            idx_q      <= 11'd0;
            o_q        <= 11'd0;
            acc_head_q <= 1'b0;
            acc_tail_q <= 1'b0;
            mode_q     <= 1'b0;
            nkij_q     <= 4'd0;
            nact_q     <= 11'd0;
            inst_q     <= IDLE_WORD;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            kk_q       <= kk_d;
            idx_q      <= idx_d;
            o_q        <= o_d;
            acc_head_q <= acc_head_d;
            acc_tail_q <= acc_tail_d;
            mode_q     <= mode_d;
            nkij_q     <= nkij_d;
            nact_q     <= nact_d;
            inst_q     <= inst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign inst = inst_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_corelet_ctrl.sv
// Directed testbench for corelet_ctrl (col=8, W_BASE=1024).
module tb_corelet_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mode_os;
    logic [3:0]  num_kij;
    logic [10:0] num_act;
    logic        ofifo_valid;
    logic [34:0] inst;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    logic [34:0] cap_inst [0:255];
    logic        cap_busy [0:255];
    logic        cap_done [0:255];
    logic        cap_vld  [0:255];
    int          cap_len;

    localparam logic [34:0] IDLE0 = 35'h1_800C_0000;
    localparam logic [34:0] IDLE1 = 35'h5_800C_0000;

    corelet_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mode_os     (mode_os),
        .num_kij     (num_kij),
        .num_act     (num_act),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    function automatic logic [34:0] mk(input logic [1:0] op, input logic l0w, input logic l0r,
                                       input logic ofr, input logic [10:0] xa, input logic xc,
                                       input logic xw, input logic [10:0] pa, input logic pc,
                                       input logic pw, input logic acc, input logic md);
        return {md, acc, pw, pc, pa, xw, xc, xa, ofr, 2'b00, l0r, l0w, op};
    endfunction

    // Expected word c cycles after the first word, for num_kij=1, num_act=4, col=8
    function automatic logic [34:0] exp1(input int c, input logic md);
        int t;
        if (c < 9) begin
            t = c;
            return mk(2'b00, t >= 1, 1'b0, 1'b0, (t < 8) ? 11'(1024 + t) : 11'd0,
                      (t < 8) ? 1'b0 : 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 1'b0, md);
        end else if (c < 17) begin
            return mk(2'b01, 1'b0, 1'b1, 1'b0, 11'd0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 1'b0, md);
        end else if (c < 22) begin
            t = c - 17;
            return mk(2'b00, t >= 1, 1'b0, 1'b0, (t < 4) ? 11'(t) : 11'd0,
                      (t < 4) ? 1'b0 : 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 1'b0, md);
        end else if (c < 26) begin
            return mk(2'b10, 1'b0, 1'b1, 1'b0, 11'd0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 1'b0, md);
        end else if (c < 30) begin
            t = c - 26;
            return mk(2'b00, 1'b0, 1'b0, 1'b1, 11'd0, 1'b1, 1'b1, 11'(t), 1'b0, 1'b0, 1'b0, md);
        end else if (c < 35) begin
            t = c - 30;
            return mk(2'b00, 1'b0, 1'b0, 1'b0, 11'd0, 1'b1, 1'b1, (t < 4) ? 11'(t) : 11'd0,
                      (t < 4) ? 1'b0 : 1'b1, 1'b1, t >= 1, md);
        end else begin
            return mk(2'b00, 1'b0, 1'b0, 1'b0, 11'd0, 1'b1, 1'b1, 11'd0, 1'b1, 1'b1, 1'b0, md);
        end
    endfunction

    // Start one operation and record one sample per cycle until done (bounded)
    task automatic run(input logic m, input logic [3:0] kij, input logic [10:0] act,
                       input bit vpat, input bit inject, input int stop_at);
        start   = 1'b1;
        mode_os = m;
        num_kij = kij;
        num_act = act;
        @(posedge clk); #1;
        start   = 1'b0;
        cap_len = 0;
        for (int c = 0; c < 256; c++) begin
            ofifo_valid = vpat ? ((c % 3) == 0) : 1'b1;
            cap_vld[c]  = ofifo_valid;
            if (inject && c == 5) begin
                start   = 1'b1;
                mode_os = ~m;
                num_act = 11'd7;
                num_kij = 4'd3;
            end else if (inject && c == 6) begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cap_inst[c] = inst;
            cap_busy[c] = busy;
            cap_done[c] = done;
            cap_len     = c + 1;
            if (done || (c + 1 == stop_at)) break;
        end
        ofifo_valid = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (inst !== IDLE0) begin
            failures++; $display("FAIL reset_inst: got %h want %h", inst, IDLE0);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL reset_flags: got busy=%b done=%b want 0 0", busy, done);
        end
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        run(1'b0, 4'd1, 11'd4, 1'b0, 1'b0, 0);
        checks++;
        if (cap_len !== 36) begin
            failures++; $display("FAIL single_len: got %0d want 36", cap_len);
        end
        for (int c = 0; c < 36 && c < cap_len; c++) begin
            checks++;
            if (cap_inst[c] !== exp1(c, 1'b0)) begin
                failures++; $display("FAIL single_inst c=%0d: got %h want %h", c, cap_inst[c], exp1(c, 1'b0));
            end
            checks++;
            if (cap_busy[c] !== (c < 35) || cap_done[c] !== (c == 35)) begin
                failures++; $display("FAIL single_flags c=%0d: got busy=%b done=%b want %b %b",
                                     c, cap_busy[c], cap_done[c], c < 35, c == 35);
            end
        end
    endtask

    task automatic test_two_kij();
        logic [10:0] wq[$];
        logic [10:0] pw[$];
        logic [10:0] pr[$];
        int          exp_rd[6];
        int          nacc;
        exp_rd = '{0, 3, 1, 4, 2, 5};
        nacc   = 0;
        run(1'b0, 4'd2, 11'd3, 1'b0, 1'b0, 0);
        checks++;
        if (cap_len !== 62 || cap_done[cap_len-1] !== 1'b1) begin
            failures++; $display("FAIL two_len: got %0d want 62", cap_len);
        end
        for (int c = 0; c < cap_len; c++) begin
            if (cap_inst[c][18] == 1'b0 && cap_inst[c][17:7] >= 11'd1024) wq.push_back(cap_inst[c][17:7]);
            if (cap_inst[c][31] == 1'b0 && cap_inst[c][32] == 1'b0) pw.push_back(cap_inst[c][30:20]);
            if (cap_inst[c][31] == 1'b0 && cap_inst[c][32] == 1'b1) begin
                pr.push_back(cap_inst[c][30:20]);
                checks++;
                if (c + 1 >= cap_len || cap_inst[c+1][33] !== 1'b1) begin
                    failures++; $display("FAIL two_sfp_after_read c=%0d: got %b want 1", c, cap_inst[c+1][33]);
                end
            end
            if (cap_inst[c][33] == 1'b1) nacc++;
        end
        checks++;
        if (wq.size() !== 16 || pw.size() !== 6 || pr.size() !== 6 || nacc !== 6) begin
            failures++; $display("FAIL two_counts: got w=%0d pw=%0d pr=%0d acc=%0d want 16 6 6 6",
                                 wq.size(), pw.size(), pr.size(), nacc);
        end
        for (int i = 0; i < wq.size() && i < 16; i++) begin
            checks++;
            if (wq[i] !== 11'(1024 + i)) begin
                failures++; $display("FAIL two_waddr i=%0d: got %0d want %0d", i, wq[i], 1024 + i);
            end
        end
        for (int i = 0; i < pw.size() && i < 6; i++) begin
            checks++;
            if (pw[i] !== 11'(i)) begin
                failures++; $display("FAIL two_drain_addr i=%0d: got %0d want %0d", i, pw[i], i);
            end
        end
        for (int i = 0; i < pr.size() && i < 6; i++) begin
            checks++;
            if (pr[i] !== 11'(exp_rd[i])) begin
                failures++; $display("FAIL two_acc_addr i=%0d: got %0d want %0d", i, pr[i], exp_rd[i]);
            end
        end
    endtask

    task automatic test_drain_stall();
        int nrd;
        nrd = 0;
        run(1'b0, 4'd1, 11'd4, 1'b1, 1'b0, 0);
        // Drain begins at c=26; valid on c%3==0 gives writes at 27,30,33,36
        checks++;
        if (cap_len !== 43) begin
            failures++; $display("FAIL stall_len: got %0d want 43", cap_len);
        end
        for (int c = 26; c < 37 && c < cap_len; c++) begin
            checks++;
            if (cap_inst[c][6] !== cap_vld[c] || cap_inst[c][31] !== ~cap_vld[c]) begin
                failures++; $display("FAIL stall_rd c=%0d: got rd=%b pcen=%b want %b %b",
                                     c, cap_inst[c][6], cap_inst[c][31], cap_vld[c], ~cap_vld[c]);
            end
            if (cap_inst[c][6] == 1'b1) begin
                checks++;
                if (cap_inst[c][30:20] !== 11'(nrd) || cap_inst[c][32] !== 1'b0) begin
                    failures++; $display("FAIL stall_addr c=%0d: got %0d want %0d", c, cap_inst[c][30:20], nrd);
                end
                nrd++;
            end
        end
        checks++;
        if (nrd !== 4) begin
            failures++; $display("FAIL stall_beats: got %0d want 4", nrd);
        end
        checks++;
        if (cap_len > 37 && cap_inst[37][31:30] !== 2'b00) begin
            failures++; $display("FAIL stall_acc_start: got %h want pmem read of addr 0", cap_inst[37]);
        end
    endtask

    task automatic test_zero_act();
        run(1'b1, 4'd2, 11'd0, 1'b0, 1'b0, 0);
        checks++;
        if (cap_len !== 1 || cap_done[0] !== 1'b1 || cap_busy[0] !== 1'b0) begin
            failures++; $display("FAIL zero_done: got len=%0d done=%b busy=%b want 1 1 0",
                                 cap_len, cap_done[0], cap_busy[0]);
        end
        checks++;
        if (cap_inst[0] !== IDLE1) begin
            failures++; $display("FAIL zero_inst: got %h want %h", cap_inst[0], IDLE1);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || inst !== IDLE1) begin
            failures++; $display("FAIL zero_after: got done=%b inst=%h want 0 %h", done, inst, IDLE1);
        end
    endtask

    task automatic test_reset_abort();
        run(1'b1, 4'd2, 11'd3, 1'b0, 1'b0, 50);
        checks++;
        if (cap_len !== 50 || cap_inst[49][1:0] !== 2'b10 || cap_busy[49] !== 1'b1) begin
            failures++; $display("FAIL abort_in_exec: got len=%0d op=%b busy=%b want 50 10 1",
                                 cap_len, cap_inst[49][1:0], cap_busy[49]);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (inst !== IDLE0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL abort_reset: got inst=%h busy=%b done=%b want %h 0 0",
                                 inst, busy, done, IDLE0);
        end
        @(negedge clk) reset = 1'b1;
        @(posedge clk); #1;
        run(1'b0, 4'd2, 11'd3, 1'b0, 1'b0, 0);
        checks++;
        if (cap_inst[0] !== mk(2'b00, 1'b0, 1'b0, 1'b0, 11'd1024, 1'b0, 1'b1, 11'd0, 1'b1, 1'b1, 1'b0, 1'b0)) begin
            failures++; $display("FAIL abort_restart_first: got %h want addr 1024 read", cap_inst[0]);
        end
        checks++;
        if (cap_inst[27] !== mk(2'b00, 1'b0, 1'b0, 1'b0, 11'd1032, 1'b0, 1'b1, 11'd0, 1'b1, 1'b1, 1'b0, 1'b0)) begin
            failures++; $display("FAIL abort_restart_k1: got %h want addr 1032 read", cap_inst[27]);
        end
        checks++;
        if (cap_len !== 62) begin
            failures++; $display("FAIL abort_restart_len: got %0d want 62", cap_len);
        end
    endtask

    task automatic test_busy_ignore();
        run(1'b1, 4'd1, 11'd4, 1'b0, 1'b1, 0);
        checks++;
        if (cap_len !== 36) begin
            failures++; $display("FAIL ignore_len: got %0d want 36", cap_len);
        end
        for (int c = 0; c < 36 && c < cap_len; c++) begin
            checks++;
            if (cap_inst[c] !== exp1(c, 1'b1)) begin
                failures++; $display("FAIL ignore_inst c=%0d: got %h want %h", c, cap_inst[c], exp1(c, 1'b1));
            end
        end
        @(posedge clk); #1;
        checks++;
        if (inst !== IDLE1 || done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL ignore_after: got inst=%h done=%b busy=%b want %h 0 0",
                                 inst, done, busy, IDLE1);
        end
    endtask

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        mode_os     = 1'b0;
        num_kij     = 4'd0;
        num_act     = 11'd0;
        ofifo_valid = 1'b1;
        test_reset();
        test_single();
        test_two_kij();
        test_drain_stall();
        test_zero_act();
        test_reset_abort();
        test_busy_ignore();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
